alu_seq: RTL
============

# alu_seq

Parametrised, registered successor to the 4-bit load/operate ALU. It holds two W-bit operand registers loaded from a shared `din` bus, executes eight operations on a `start` strobe, and reports `out` with `cout`, `zero` and `overflow` flags. Single-cycle operations complete in one cycle. MUL runs as a multi-cycle shift-add sequence with `busy`/`done` handshaking. It sits as the datapath execute unit behind the operand-load controller.

## Interface
- `W`, default 8: operand/result width; legal W ≥ 2.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-high reset.
- `ld_a`  in  1: load `din` into A at the edge; ignored while `busy`.
- `ld_b`  in  1: load `din` into B at the edge; ignored while `busy`.
- `din`  in  W: operand load bus.
- `control`  in  3: opcode, sampled only on an accepted `start`.
- `start`  in  1: begin an operation; accepted only when idle.
- `busy`  out  1: high while MUL iterates.
- `done`  out  1: one-cycle pulse when `out` and flags update.
- `out`  out  W: registered result; holds until the next completion.
- `cout`  out  1: registered carry flag.
- `zero`  out  1: registered, equals (`out` == 0).
- `overflow`  out  1: registered overflow flag.

## Operation
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A+~B+1.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 NOT A.
  - 110 SHL: A<<1, LSB 0.
  - 111 MUL: unsigned, low W bits of A·B.
- Flags:
  - ADD/SUB: `cout` = carry out of bit W-1, so SUB gives `cout`=1 iff A ≥ B unsigned. `overflow` = signed two's-complement overflow.
  - Logic ops: `cout`=0, `overflow`=0.
  - SHL: `cout`=A[W-1], `overflow`=A[W-1]^A[W-2].
  - MUL: `cout`=0, `overflow`=1 iff the upper W bits of the 2W product are nonzero.
- Result capture: `out`, `cout`, `zero` and `overflow` update together, only in the cycle `done` rises.
- FSM:
  - IDLE: `start` with `control`≠111 writes the result at that edge; `done`=1 next cycle; stay IDLE. `start` with 111 latches A, B, clears the 2W accumulator and counter, goes to MUL.
  - MUL: each edge performs one iteration (add shifted multiplicand if multiplier LSB set; shift). Counter width $clog2(W). On the edge with counter = W-1, do the final iteration, write the result and flags, set `done`, return to IDLE.
- Boundary conditions:
  - `ld_a`/`ld_b` with `start` in the same IDLE cycle: the operation uses the pre-edge A/B; the loads still take effect.
  - `ld_a` and `ld_b` together load both registers with `din`.
  - `start`, `ld_a` and `ld_b` while `busy` are ignored, with no queuing.
  - `start` in the same cycle `done` is high is accepted, since the FSM is in IDLE.
  - `rst` mid-MUL aborts: no `done`, state IDLE.
- Reset values: A, B, `out`, `cout`, `overflow`, `busy`, `done` = 0; `zero` = 1 (consistent with `out`=0); state IDLE.

## Timing
- Single-cycle op: `start` sampled at edge k → `out`/flags valid and `done`=1 in cycle k+1, for exactly one cycle.
- MUL: `start` at edge k → `busy`=1 during cycles k+1..k+W; the result is written at edge k+W; `done`=1 in cycle k+W+1 with `busy`=0.
- Operand load: a register written at edge k is usable by a `start` at edge k+1 or later.
- No combinational path from any input to any output.

## Structure
- Package `alu_pkg`:
  - opcode enum: `OP_ADD`..`OP_MUL`, 3 bits.
  - FSM state enum: `S_IDLE`, `S_MUL`.
- Sub-module `alu_mul_seq`: shift-add multiplier with parameter W.
  - Inputs: `clk`, `rst`, `go`, `a`, `b`.
  - Outputs: `prod[2W-1:0]`, `last`.
  - The top module owns the FSM, operand registers, single-cycle datapath and flag logic.

## Test plan
All scenarios use W=8.
- Reset, load A=0x05, B=0x03, ADD → `out`=0x08, `cout`=0, `overflow`=0, `zero`=0; `done` high exactly one cycle, one cycle after `start`.
- SUB 0x03−0x05 → 0xFE, `cout`=0, `overflow`=0. SUB 0x05−0x05 → 0x00, `cout`=1, `zero`=1.
- ADD 0x7F+0x01 → 0x80, `overflow`=1, `cout`=0. ADD 0xFF+0x01 → 0x00, `cout`=1, `zero`=1. SHL A=0x40 → 0x80, `cout`=0, `overflow`=1.
- MUL 0x0F×0x0D → 0xC3, `overflow`=0, `busy` high 8 cycles, `done` in cycle k+9. MUL 0x10×0x10 → 0x00, `overflow`=1, `zero`=1.
- During MUL busy, pulse `start` and `ld_a` with `din`=0xAA → both ignored, A unchanged, one `done` only. Assert `rst` mid-MUL → `busy`=0 next cycle, no `done`, `out`=0.
- Same-cycle `ld_a` (`din`=0x01) and `start` ADD with A=0x05, B=0x03 → `out`=0x08. A following ADD → `out`=0x04.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode and FSM state types shared by the sequential ALU.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_MUL = 3'b111
    } opcode_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand load, command and result bundle of the sequential ALU.
interface alu_seq_if #(parameter int W = 8);
    logic         ld_a;
    logic         ld_b;
    logic [W-1:0] din;
    logic [2:0]   control;
    logic         start;
    logic         busy;
    logic         done;
    logic [W-1:0] out;
    logic         cout;
    logic         zero;
    logic         overflow;

    modport master (
        output ld_a, ld_b, din, control, start,
        input  busy, done, out, cout, zero, overflow
    );

    modport slave (
        input  ld_a, ld_b, din, control, start,
        output busy, done, out, cout, zero, overflow
    );
endinterface

// File: rtl/alu_mul_seq.sv
// rtl/alu_mul_seq.sv - shift-add multiplier, one partial product per clock, W iterations.
module alu_mul_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           go,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] prod,
    output logic           last
);
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [2*W-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           active;

    // prod is the accumulator after the current iteration, so the owner can
    // capture the finished product on the same edge as the final step.
    assign prod = acc + (mplier[0] ? mcand : '0);
    assign last = active && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (go) begin
            mcand  <= {{W{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            acc    <= prod;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                active <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered W-bit ALU: operand registers, single-cycle ops, sequential MUL.
module alu_seq
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);
    state_t         state;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   out_q;
    logic           cout_q;
    logic           zero_q;
    logic           ovf_q;
    logic           done_q;

    logic [W:0]     sum;
    logic [W-1:0]   res;
    logic           res_c;
    logic           res_v;
    logic [2*W-1:0] prod;
    logic           mul_last;
    logic           go;
    opcode_t        op;

    assign op  = opcode_t'(bus.control);
    assign go  = (state == S_IDLE) && bus.start && (op == OP_MUL);

    assign bus.busy     = (state == S_MUL);
    assign bus.done     = done_q;
    assign bus.out      = out_q;
    assign bus.cout     = cout_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = ovf_q;

    alu_mul_seq #(.W(W)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .go   (go),
        .a    (a_q),
        .b    (b_q),
        .prod (prod),
        .last (mul_last)
    );

    always_comb begin
        sum   = '0;
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, a_q} + {1'b0, b_q};
                res   = sum[W-1:0];
                res_c = sum[W];
                res_v = (a_q[W-1] == b_q[W-1]) && (res[W-1] != a_q[W-1]);
            end
            OP_SUB: begin
                sum   = {1'b0, a_q} + {1'b0, ~b_q} + {{W{1'b0}}, 1'b1};
                res   = sum[W-1:0];
                res_c = sum[W];
                res_v = (a_q[W-1] != b_q[W-1]) && (res[W-1] != a_q[W-1]);
            end
            OP_AND: res = a_q & b_q;
            OP_OR:  res = a_q | b_q;
            OP_XOR: res = a_q ^ b_q;
            OP_NOT: res = ~a_q;
            OP_SHL: begin
                res   = {a_q[W-2:0], 1'b0};
                res_c = a_q[W-1];
                res_v = a_q[W-1] ^ a_q[W-2];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            out_q  <= '0;
            cout_q <= 1'b0;
            zero_q <= 1'b1;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    // Operation reads the pre-edge operands; same-cycle loads still land.
                    if (bus.ld_a) a_q <= bus.din;
                    if (bus.ld_b) b_q <= bus.din;
                    if (bus.start) begin
                        if (op == OP_MUL) begin
                            state <= S_MUL;
                        end else begin
                            out_q  <= res;
                            cout_q <= res_c;
                            zero_q <= (res == '0);
                            ovf_q  <= res_v;
                            done_q <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_last) begin
                        out_q  <= prod[W-1:0];
                        cout_q <= 1'b0;
                        zero_q <= (prod[W-1:0] == '0);
                        ovf_q  <= |prod[2*W-1:W];
                        done_q <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
